cpu6_mmu: RTL and testbench
===========================

Name: cpu6_mmu

Overview:
Downstream of the CPU6 core on its memory side. The block translates each 16-bit logical bus address into an 18-bit physical address using a page table indexed by the current map number. It enforces write protection per page and runs a req/ack handshake to the memory system, absorbing any memory wait states. It also supplies the translated high address bits that the core reads back on DP-bus source 8.

Parameters:
MAP_BITS, 3, width of map-select register; 2^MAP_BITS maps
PAGE_BITS, 5, logical page-select bits, taken from cpu_addr[15:11]
PPAGE_W, 7, physical page number width; physical address width is PPAGE_W+11 = 18

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
map_load  in  1  load map_sel from map_data (core e6==4 strobe)
map_data  in  MAP_BITS  new map number
pt_we  in  1  page-table write strobe
pt_addr  in  MAP_BITS+PAGE_BITS  page-table entry index, {map, page}
pt_data  in  8  entry value: [7] write-protect, [6:0] physical page
xlat_en  in  1  1 = translate; 0 = bypass (identity)
cpu_req  in  1  one-cycle start-of-access pulse
cpu_we  in  1  access is a write (sampled with cpu_req)
cpu_addr  in  16  logical address (sampled with cpu_req)
cpu_wdata  in  8  write data (sampled with cpu_req)
cpu_busy  out  1  access in progress
cpu_ready  out  1  one-cycle completion pulse
cpu_fault  out  1  with cpu_ready: access aborted by write-protect
cpu_rdata  out  8  read data, valid from cpu_ready onward until next completion
xlat_hi  out  8  {1'b0, physical page of last lookup} for DP-bus source 8
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  PPAGE_W+11  physical address
mem_wdata  out  8  write data
mem_rdata  in  8  memory read data, valid with mem_ack
mem_ack  in  1  memory completion; may arrive 0..N cycles after mem_req rises

Behaviour:
- Reset (reset=0, asynchronous):
  - map_sel=0, state=IDLE.
  - All outputs 0; mem_req drops immediately.
  - Page table contents are NOT reset.
- Page table: 2^(MAP_BITS+PAGE_BITS) x 8 registers, written synchronously on pt_we.
  - The read in LOOKUP sees the pre-write value if pt_we targets the same entry in that cycle.
- map_load takes effect on the next edge. An in-flight access keeps the map index it captured at cpu_req.
- FSM states: IDLE, LOOKUP, BUS, DONE.
  - IDLE: on cpu_req, capture we/addr/wdata/map_sel, go to LOOKUP, assert cpu_busy. cpu_req is ignored in any other state.
  - LOOKUP (1 cycle): read entry at {captured map, addr[15:11]}; register the physical page; update xlat_hi.
    - If xlat_en=0: physical page = {2'b00, addr[15:11]} and write-protect is ignored.
    - If cpu_we=1 and WP=1: go to DONE with fault.
    - Otherwise: go to BUS with mem_req=1.
  - BUS: hold mem_req, mem_we, mem_addr={ppage, addr[10:0]} and mem_wdata stable until the cycle mem_ack=1.
    - On that edge: drop mem_req, latch mem_rdata into cpu_rdata (reads only), go to DONE.
    - mem_ack seen outside BUS is ignored.
  - DONE (1 cycle): cpu_ready=1, cpu_fault as determined in LOOKUP, cpu_busy=0; next state IDLE.
    - A cpu_req arriving in DONE is ignored; the core waits for cpu_ready before issuing the next request.
- Latency from cpu_req to cpu_ready:
  - 3 cycles + memory wait cycles (zero-wait ack in the first BUS cycle gives 3).
  - 2 cycles on a fault.
- Fault accesses never assert mem_req. cpu_rdata is unchanged on faults and writes.
- Width rules: physical address = PPAGE_W+11 bits, no arithmetic carry between page and offset; the offset wraps within the 2 KB page.

Decomposition:
- Shared package cpu6_mmu_pkg holds:
  - state enum (IDLE/LOOKUP/BUS/DONE);
  - entry field constants (WP_BIT=7, PPAGE_MSB=6);
  - OFFSET_W=11.
- One natural sub-module: cpu6_page_table, the synchronous-write, registered-read entry RAM with read-before-write semantics.

Test Plan:
- Translated read:
  - Stimulus: write pt[{3'd2, 5'h1F}]=8'h45; map_load 2; xlat_en=1; read 16'hF812 with mem_ack after 2 wait cycles and mem_rdata=8'hA5.
  - Required: mem_addr=18'h22812, xlat_hi=8'h45, cpu_ready 5 cycles after cpu_req, cpu_rdata=8'hA5.
- Write-protect fault:
  - Stimulus: pt[{3'd0, 5'h03}]=8'h80|8'h10; write 16'h1ABC.
  - Required: cpu_ready and cpu_fault at cycle 2, mem_req never asserted. A read of the same address succeeds with mem_addr=18'h082BC.
- Bypass:
  - Stimulus: xlat_en=0; write 16'hC001 data 8'h5A to a WP page; zero-wait ack.
  - Required: mem_addr=18'h0C001, mem_we=1, mem_wdata=8'h5A, no fault, ready at cycle 3.
- Same-cycle update:
  - Stimulus: pt_we to entry {0, 5'h00} with 8'h22 in the LOOKUP cycle of an access to 16'h0000 whose old entry is 8'h11.
  - Required: mem_addr=18'h08800. A following access gives 18'h11000.
- Map change mid-access:
  - Stimulus: map_load 5 during BUS of a map-1 access.
  - Required: that access uses map 1; the next access uses map 5.
- Reset during BUS:
  - Stimulus: assert reset with mem_req=1.
  - Required: mem_req, cpu_busy and cpu_ready fall without waiting for a clock edge. After release: IDLE, map_sel=0, and the prior page-table contents are still readable through a translation.

Source files
------------

// File: rtl/cpu6_mmu_pkg.sv
// cpu6_mmu_pkg
// Shared types and constants for the CPU6 memory-management unit.
//   - Geometry: map-select width, logical page bits, physical page width.
//   - Page-table entry layout: [7] write-protect, [6:0] physical page.
//   - FSM state encoding shared by the top level.
package cpu6_mmu_pkg;

    localparam int MAP_BITS  = 3;                     // 2^MAP_BITS maps
    localparam int PAGE_BITS = 5;                     // logical page = cpu_addr[15:11]
    localparam int PPAGE_W   = 7;                     // physical page number width
    localparam int OFFSET_W  = 11;                    // 2 KB pages
    localparam int PADDR_W   = PPAGE_W + OFFSET_W;    // 18-bit physical address
    localparam int PT_AW     = MAP_BITS + PAGE_BITS;  // page-table index {map, page}

    localparam int WP_BIT    = 7;                     // entry write-protect flag
    localparam int PPAGE_MSB = 6;                     // entry physical page [6:0]

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        BUS    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/cpu6_page_table.sv
// cpu6_page_table
// Page-table entry RAM: synchronous write, registered read. A read and a
// write to the same entry on one edge return the old contents (the read
// samples the array before the non-blocking write lands). Contents are
// deliberately not reset.
// Ports:
//   clock          rising-edge clock
//   we/waddr/wdata write port
//   re/raddr       read enable and index; rdata updates only when re=1
//   rdata          registered read data
module cpu6_page_table #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cpu6_mmu.sv
// cpu6_mmu
// Translates 16-bit logical CPU addresses into 18-bit physical addresses
// through a per-map page table, enforces per-page write protection and
// runs a req/ack handshake to memory that absorbs wait states.
// Ports:
//   clock, reset (async, active-low)
//   map_load/map_data        select the current map (next edge)
//   pt_we/pt_addr/pt_data    page-table write port, index {map, page}
//   xlat_en                  1 = translate, 0 = identity bypass
//   cpu_req/we/addr/wdata    access start pulse and its operands
//   cpu_busy/ready/fault     access status; cpu_rdata read result
//   xlat_hi                  {0, physical page of last lookup}
//   mem_req/we/addr/wdata    memory request, held until mem_ack
//   mem_rdata/mem_ack        memory response
module cpu6_mmu
    import cpu6_mmu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                map_load,
    input  logic [MAP_BITS-1:0] map_data,
    input  logic                pt_we,
    input  logic [PT_AW-1:0]    pt_addr,
    input  logic [7:0]          pt_data,
    input  logic                xlat_en,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [15:0]         cpu_addr,
    input  logic [7:0]          cpu_wdata,
    output logic                cpu_busy,
    output logic                cpu_ready,
    output logic                cpu_fault,
    output logic [7:0]          cpu_rdata,
    output logic [7:0]          xlat_hi,
    output logic                mem_req,
    output logic                mem_we,
    output logic [PADDR_W-1:0]  mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ack
);

    state_t                state_reg, state_next;
    logic [MAP_BITS-1:0]   map_sel_reg;
    logic                  we_reg;
    logic [15:0]           addr_reg;
    logic [7:0]            wdata_reg;
    logic [PPAGE_W-1:0]    ppage_reg;
    logic                  fault_reg;
    logic [7:0]            xlat_hi_reg;
    logic [7:0]            rdata_reg;
    logic                  fwd_hit_reg;
    logic [7:0]            fwd_data_reg;

    logic                  pt_re;
    logic [PT_AW-1:0]      pt_raddr;
    logic [7:0]            pt_rdata;
    logic [7:0]            entry;
    logic [PPAGE_W-1:0]    lookup_ppage;
    logic                  lookup_wp;
    logic                  lookup_fault;

    // The entry is fetched on the cpu_req edge using the map selected at
    // that moment, so LOOKUP has it in hand and can decide fault vs. bus.
    assign pt_re    = (state_reg == IDLE) && cpu_req;
    assign pt_raddr = {map_sel_reg, cpu_addr[15 -: PAGE_BITS]};

    cpu6_page_table #(
        .AW (PT_AW),
        .DW (8)
    ) u_page_table (
        .clock (clock),
        .we    (pt_we),
        .waddr (pt_addr),
        .wdata (pt_data),
        .re    (pt_re),
        .raddr (pt_raddr),
        .rdata (pt_rdata)
    );

    // A table write landing on the same edge as the fetch must still be
    // visible in LOOKUP, so it is forwarded around the RAM. Writes made
    // during LOOKUP itself do not affect the access in flight.
    assign entry = fwd_hit_reg ? fwd_data_reg : pt_rdata;

    always_comb begin
        if (xlat_en) begin
            lookup_ppage = entry[PPAGE_MSB:0];
            lookup_wp    = entry[WP_BIT];
        end else begin
            lookup_ppage = {{(PPAGE_W-PAGE_BITS){1'b0}}, addr_reg[15 -: PAGE_BITS]};
            lookup_wp    = 1'b0;
        end
        lookup_fault = we_reg && lookup_wp;
    end

    always_comb begin
        state_next = state_reg;
        cpu_busy   = 1'b0;
        cpu_ready  = 1'b0;
        cpu_fault  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                cpu_busy   = 1'b1;
                state_next = lookup_fault ? DONE : BUS;
            end
            BUS: begin
                cpu_busy = 1'b1;
                mem_req  = 1'b1;
                mem_we   = we_reg;
                if (mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_ready  = 1'b1;
                cpu_fault  = fault_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            map_sel_reg  <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            ppage_reg    <= '0;
            fault_reg    <= 1'b0;
            xlat_hi_reg  <= '0;
            rdata_reg    <= '0;
            fwd_hit_reg  <= 1'b0;
            fwd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (map_load) begin
                map_sel_reg <= map_data;
            end
            if (pt_re) begin
                we_reg       <= cpu_we;
                addr_reg     <= cpu_addr;
                wdata_reg    <= cpu_wdata;
                fwd_hit_reg  <= pt_we && (pt_addr == pt_raddr);
                fwd_data_reg <= pt_data;
            end
            if (state_reg == LOOKUP) begin
                ppage_reg   <= lookup_ppage;
                fault_reg   <= lookup_fault;
                xlat_hi_reg <= {1'b0, lookup_ppage};
            end
            if ((state_reg == BUS) && mem_ack && !we_reg) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    // Page and offset are concatenated, never added: the offset wraps
    // inside its 2 KB page.
    assign mem_addr  = {ppage_reg, addr_reg[OFFSET_W-1:0]};
    assign mem_wdata = wdata_reg;
    assign cpu_rdata = rdata_reg;
    assign xlat_hi   = xlat_hi_reg;

endmodule

// File: tb/tb_cpu6_mmu.sv
// tb_cpu6_mmu
// Self-checking bench for cpu6_mmu. A transaction-level model (page-table
// array, current map, latency arithmetic) predicts every output on every
// cycle; directed scenarios add literal expectations.
module tb_cpu6_mmu;

    logic        clock = 1'b0;
    logic        reset;
    logic        map_load;
    logic [2:0]  map_data;
    logic        pt_we;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_data;
    logic        xlat_en;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ready;
    logic        cpu_fault;
    logic [7:0]  cpu_rdata;
    logic [7:0]  xlat_hi;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    cpu6_mmu dut (
        .clock     (clock),
        .reset     (reset),
        .map_load  (map_load),
        .map_data  (map_data),
        .pt_we     (pt_we),
        .pt_addr   (pt_addr),
        .pt_data   (pt_data),
        .xlat_en   (xlat_en),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_busy  (cpu_busy),
        .cpu_ready (cpu_ready),
        .cpu_fault (cpu_fault),
        .cpu_rdata (cpu_rdata),
        .xlat_hi   (xlat_hi),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0]  pt_m [256];
    logic [2:0]  m_map;
    logic [7:0]  m_xhi;
    logic [7:0]  m_rdata;
    bit          chk_en;

    // Access in flight
    bit          tx_valid;
    int          tx_start;
    int          tx_w;
    bit          tx_we;
    bit          tx_fault;
    logic [17:0] tx_addr;
    logic [7:0]  tx_wdata;
    logic [7:0]  tx_rdata;
    logic [7:0]  tx_xhi;

    // Observations gathered by the driver for directed checks
    bit          obs_req_seen;
    int          obs_ready_k;
    bit          obs_fault;
    bit          obs_we;
    logic [17:0] obs_addr;
    logic [7:0]  obs_wdata;

    // Literal expectations are queued and evaluated by the compare process
    string       lit_name [$];
    logic [31:0] lit_act  [$];
    logic [31:0] lit_exp  [$];

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_name.push_back(n);
        lit_act.push_back(a);
        lit_exp.push_back(e);
    endtask

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, a, e);
        end
    endtask

    int          c_k;
    int          c_done;
    bit          e_busy, e_ready, e_fault, e_req;
    logic [7:0]  e_xhi, e_rd;

    always @(negedge clock) begin
        while (lit_name.size() > 0) begin
            cmp(lit_name[0], lit_act[0], lit_exp[0]);
            void'(lit_name.pop_front());
            void'(lit_act.pop_front());
            void'(lit_exp.pop_front());
        end
        if (chk_en) begin
            e_busy  = 1'b0;
            e_ready = 1'b0;
            e_fault = 1'b0;
            e_req   = 1'b0;
            e_xhi   = m_xhi;
            e_rd    = m_rdata;
            if (tx_valid) begin
                c_k    = cyc - tx_start;
                c_done = tx_fault ? 2 : 3 + tx_w;
                e_busy  = (c_k >= 1) && (c_k < c_done);
                e_ready = (c_k == c_done);
                e_fault = e_ready && tx_fault;
                e_req   = !tx_fault && (c_k >= 2) && (c_k <= 2 + tx_w);
                if (c_k >= 2) e_xhi = tx_xhi;
                if ((c_k >= c_done) && !tx_we && !tx_fault) e_rd = tx_rdata;
            end
            cmp("cpu_busy",  32'(cpu_busy),  32'(e_busy));
            cmp("cpu_ready", 32'(cpu_ready), 32'(e_ready));
            cmp("cpu_fault", 32'(cpu_fault), 32'(e_fault));
            cmp("mem_req",   32'(mem_req),   32'(e_req));
            cmp("xlat_hi",   32'(xlat_hi),   32'(e_xhi));
            cmp("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
            if (e_req) begin
                cmp("mem_addr", 32'(mem_addr), 32'(tx_addr));
                cmp("mem_we",   32'(mem_we),   32'(tx_we));
                if (tx_we) cmp("mem_wdata", 32'(mem_wdata), 32'(tx_wdata));
            end
        end
    end

    task automatic pt_write(input logic [7:0] a, input logic [7:0] d);
        pt_we   = 1'b1;
        pt_addr = a;
        pt_data = d;
        pt_m[a] = d;
        @(posedge clock); #1;
        pt_we   = 1'b0;
    endtask

    task automatic map_set(input logic [2:0] v);
        map_load = 1'b1;
        map_data = v;
        m_map    = v;
        @(posedge clock); #1;
        map_load = 1'b0;
    endtask

    task automatic idle_rand(input int n);
        for (int i = 0; i < n; i++) begin
            pt_we = ($urandom_range(0, 1) == 1);
            if (pt_we) begin
                pt_addr = 8'($urandom);
                pt_data = 8'($urandom);
                pt_m[pt_addr] = pt_data;
            end
            map_load = ($urandom_range(0, 3) == 0);
            if (map_load) begin
                map_data = 3'($urandom);
                m_map    = map_data;
            end
            mem_ack   = 1'($urandom);
            mem_rdata = 8'($urandom);
            cpu_req   = 1'b0;
            @(posedge clock); #1;
            pt_we    = 1'b0;
            map_load = 1'b0;
            mem_ack  = 1'b0;
        end
    endtask

    // One complete access. w = memory wait cycles before ack. wr_k/ml_k
    // place a table write / map load in cycle k after the request.
    task automatic access(input bit we, input logic [15:0] a, input logic [7:0] d,
                          input int w, input logic [7:0] rd, input bit xen,
                          input int wr_k, input logic [7:0] wr_a, input logic [7:0] wr_d,
                          input int ml_k, input logic [2:0] ml_v, input bit rnd);
        logic [7:0] ent;
        logic [6:0] pp;
        bit         wp;
        int         done_k;
        ent = pt_m[{m_map, a[15:11]}];
        if (xen) begin
            pp = ent[6:0];
            wp = ent[7];
        end else begin
            pp = {2'b00, a[15:11]};
            wp = 1'b0;
        end
        tx_we    = we;
        tx_fault = we && wp;
        tx_w     = w;
        tx_addr  = {pp, a[10:0]};
        tx_wdata = d;
        tx_rdata = rd;
        tx_xhi   = {1'b0, pp};
        done_k   = tx_fault ? 2 : 3 + w;
        obs_req_seen = 1'b0;
        obs_ready_k  = -1;
        obs_fault    = 1'b0;
        obs_we       = 1'b0;
        obs_addr     = '0;
        obs_wdata    = '0;

        xlat_en   = xen;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        mem_ack   = 1'b0;
        tx_start  = cyc;
        tx_valid  = 1'b1;

        for (int k = 1; k <= done_k; k++) begin
            @(posedge clock); #1;
            if (mem_req) begin
                obs_req_seen = 1'b1;
                obs_addr     = mem_addr;
                obs_we       = mem_we;
                obs_wdata    = mem_wdata;
            end
            if (cpu_ready) begin
                obs_ready_k = k;
                obs_fault   = cpu_fault;
            end
            pt_we     = 1'b0;
            map_load  = 1'b0;
            cpu_req   = rnd ? 1'($urandom) : 1'b0;
            cpu_we    = 1'($urandom);
            cpu_addr  = 16'($urandom);
            cpu_wdata = 8'($urandom);
            if (!tx_fault && (k == 2 + w)) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack   = (rnd && ((k == 1) || (k == done_k))) ? 1'($urandom) : 1'b0;
                mem_rdata = 8'($urandom);
            end
            if (k == wr_k) begin
                pt_we = 1'b1; pt_addr = wr_a; pt_data = wr_d; pt_m[wr_a] = wr_d;
            end else if (rnd && ($urandom_range(0, 3) == 0)) begin
                pt_we = 1'b1; pt_addr = 8'($urandom); pt_data = 8'($urandom);
                pt_m[pt_addr] = pt_data;
            end
            if (k == ml_k) begin
                map_load = 1'b1; map_data = ml_v; m_map = ml_v;
            end else if (rnd && ($urandom_range(0, 5) == 0)) begin
                map_load = 1'b1; map_data = 3'($urandom); m_map = map_data;
            end
        end
        @(posedge clock); #1;
        cpu_req  = 1'b0;
        mem_ack  = 1'b0;
        pt_we    = 1'b0;
        map_load = 1'b0;
        m_xhi    = tx_xhi;
        if (!we && !tx_fault) m_rdata = rd;
        tx_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; chk_en = 1'b0; tx_valid = 1'b0;
        map_load = 1'b0; map_data = '0; pt_we = 1'b0; pt_addr = '0; pt_data = '0;
        xlat_en = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        m_map = '0; m_xhi = '0; m_rdata = '0;

        repeat (3) @(posedge clock);
        #1;
        lit("rst_busy",   32'(cpu_busy),  32'd0);
        lit("rst_ready",  32'(cpu_ready), 32'd0);
        lit("rst_fault",  32'(cpu_fault), 32'd0);
        lit("rst_memreq", 32'(mem_req),   32'd0);
        lit("rst_memwe",  32'(mem_we),    32'd0);
        lit("rst_maddr",  32'(mem_addr),  32'd0);
        lit("rst_mwdata", 32'(mem_wdata), 32'd0);
        lit("rst_rdata",  32'(cpu_rdata), 32'd0);
        lit("rst_xhi",    32'(xlat_hi),   32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 256; i++) pt_write(8'(i), 8'($urandom));
        chk_en = 1'b1;

        // Translated read with two wait cycles
        pt_write({3'd2, 5'h1F}, 8'h45);
        map_set(3'd2);
        access(1'b0, 16'hF812, 8'h00, 2, 8'hA5, 1'b1, -1, 8'h0, 8'h0, -1, 3'd0, 1'b0);
        lit("xr_model_addr", 32'(tx_addr),     32'h22812);
        lit("xr_addr",       32'(obs_addr),    32'h22812);
        lit("xr_latency",    32'(obs_ready_k), 32'd5);
        lit("xr_xlat_hi",    32'(xlat_hi),     32'h45);
        lit("xr_rdata",      32'(cpu_rdata),   32'hA5);

        // Write-protect fault, then a read of the same page
        pt_write({3'd0, 5'h03}, 8'h90);
        map_set(3'd0);
        access(1'b1, 16'h1ABC, 8'h77, 0, 8'h00, 1'b1, -1, 8'h0, 8'h0, -1, 3'd0, 1'b0);
        lit("wp_latency", 32'(obs_ready_k),  32'd2);
        lit("wp_fault",   32'(obs_fault),    32'd1);
        lit("wp_no_req",  32'(obs_req_seen), 32'd0);
        lit("wp_rdata",   32'(cpu_rdata),    32'hA5);
        access(1'b0, 16'h1ABC, 8'h00, 1, 8'h3C, 1'b1, -1, 8'h0, 8'h0, -1, 3'd0, 1'b0);
        lit("wp_rd_addr",  32'(obs_addr),  32'h082BC);
        lit("wp_rd_fault", 32'(obs_fault), 32'd0);

        // Bypass write to a protected page
        pt_write({3'd0, 5'h18}, 8'hC7);
        access(1'b1, 16'hC001, 8'h5A, 0, 8'h00, 1'b0, -1, 8'h0, 8'h0, -1, 3'd0, 1'b0);
        lit("bp_addr",    32'(obs_addr),    32'h0C001);
        lit("bp_we",      32'(obs_we),      32'd1);
        lit("bp_wdata",   32'(obs_wdata),   32'h5A);
        lit("bp_fault",   32'(obs_fault),   32'd0);
        lit("bp_latency", 32'(obs_ready_k), 32'd3);

        // Table write in the LOOKUP cycle of the access using that entry
        pt_write({3'd0, 5'h00}, 8'h11);
        access(1'b0, 16'h0000, 8'h00, 0, 8'h01, 1'b1, 1, 8'h00, 8'h22, -1, 3'd0, 1'b0);
        lit("sc_old_addr", 32'(obs_addr), 32'h08800);
        access(1'b0, 16'h0000, 8'h00, 0, 8'h02, 1'b1, -1, 8'h0, 8'h0, -1, 3'd0, 1'b0);
        lit("sc_new_addr", 32'(obs_addr), 32'h11000);

        // Map change while an access is on the bus
        pt_write({3'd1, 5'h0A}, 8'h33);
        pt_write({3'd5, 5'h0A}, 8'h44);
        map_set(3'd1);
        access(1'b0, 16'h5123, 8'h00, 2, 8'h6B, 1'b1, -1, 8'h0, 8'h0, 3, 3'd5, 1'b0);
        lit("mc_map1_addr", 32'(obs_addr), 32'h19923);
        access(1'b0, 16'h5123, 8'h00, 0, 8'h6C, 1'b1, -1, 8'h0, 8'h0, -1, 3'd0, 1'b0);
        lit("mc_map5_addr", 32'(obs_addr), 32'h22123);

        // Asynchronous reset while the request is on the bus
        pt_write({3'd0, 5'h07}, 8'h5C);
        pt_write({3'd3, 5'h07}, 8'h01);
        map_set(3'd3);
        tx_we = 1'b0; tx_fault = 1'b0; tx_w = 20; tx_addr = 18'h00C55;
        tx_wdata = 8'h00; tx_rdata = 8'h00; tx_xhi = 8'h01;
        xlat_en = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3C55;
        tx_start = cyc; tx_valid = 1'b1;
        @(posedge clock); #1; cpu_req = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        lit("rb_req_before",  32'(mem_req),  32'd1);
        lit("rb_addr_before", 32'(mem_addr), 32'h00C55);
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        lit("rb_req_async",   32'(mem_req),   32'd0);
        lit("rb_busy_async",  32'(cpu_busy),  32'd0);
        lit("rb_ready_async", 32'(cpu_ready), 32'd0);
        tx_valid = 1'b0; m_map = '0; m_xhi = '0; m_rdata = '0;
        @(posedge clock); #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        lit("rb_xhi_after", 32'(xlat_hi), 32'd0);
        access(1'b0, 16'h3C55, 8'h00, 1, 8'h9E, 1'b1, -1, 8'h0, 8'h0, -1, 3'd0, 1'b0);
        lit("rb_map0_addr", 32'(obs_addr), 32'h2E455);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            idle_rand($urandom_range(0, 2));
            access(1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 3),
                   8'($urandom), ($urandom_range(0, 3) != 0), -1, 8'h0, 8'h0, -1, 3'd0, 1'b1);
        end

        @(negedge clock);
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
